register_bank_param: RTL and testbench
======================================

// Module: register_bank_param
// PURPOSE
// - Parametrised register file for the datapath: 2 combinational read ports, 1 synchronous write port.
// - Register 0 is optionally hardwired to zero.
// - Adds a hardware clear sequencer. The array is zeroed one entry per cycle after reset, or on request.
//   Software-visible state is therefore deterministic without a reset on every storage bit.
// - Sits between decode (read addresses) and writeback (write address/data).
// PARAMETERS
// - DATA_W    64  width of each register in bits
// - ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
// - ZERO_REG  1   1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
// - clk       in   1       rising-edge clock
// - rst       in   1       asynchronous reset, active-high
// - raddr1    in   ADDR_W  read port 1 address
// - raddr2    in   ADDR_W  read port 2 address
// - waddr     in   ADDR_W  write address
// - wdata     in   DATA_W  write data
// - regwrite  in   1       write enable, sampled on rising clk
// - clear     in   1       1-cycle request to zero the whole array
// - busy      out  1       1 while the clear sequence runs; writes are dropped, reads return 0
// - rdata1    out  DATA_W  read port 1 data
// - rdata2    out  DATA_W  read port 2 data
// BEHAVIOUR
// - FSM states: IDLE, CLEAR. Clear pointer clr_ptr is ADDR_W bits.
// - Reset (asynchronous):
//   - state=CLEAR, clr_ptr=0, busy=1, rdata1=rdata2=0, independent of clk.
//   - Array contents are undefined until the sweep completes.
// - CLEAR state, each rising edge:
//   - Bank[clr_ptr] <= 0 and clr_ptr++.
//   - On the edge where clr_ptr==DEPTH-1, state goes to IDLE.
//   - busy is high for exactly DEPTH rising edges after rst deasserts (or after clear is accepted).
// - CLEAR state, inputs:
//   - regwrite is ignored; the write is lost and is never queued.
//   - clear is ignored; the sweep is not restarted.
// - rst asserted mid-sweep: clr_ptr restarts at 0 and a full DEPTH-cycle sweep follows.
// - IDLE state:
//   - clear=1 at a rising edge: state goes to CLEAR with clr_ptr=0; busy rises after that edge.
//   - clear and regwrite on the same edge: clear wins and the write is dropped.
//   - Otherwise regwrite=1 gives Bank[waddr] <= wdata at the edge; the new value is readable the following cycle.
//   - ZERO_REG=1 and waddr==0: the write is discarded.
// - Reads are combinational from raddr, with zero latency.
//   - rdata = 0 when busy=1, or when ZERO_REG=1 and raddr==0.
//   - Both ports may address the same entry; both return the same data.
// - Widths: there is no arithmetic on data. clr_ptr wraps naturally at DEPTH-1 and no out-of-range address exists.
// CONFIGURATION
// - Macro REGBANK_BYPASS_EN.
// - Defined: write-through forwarding. In IDLE with regwrite=1 and !clear, a read port with raddrN==waddr
//   (and, when ZERO_REG=1, waddr!=0) returns wdata in the same cycle.
// - Undefined: a read port returns the stored (old) value in the write cycle; the new value appears the next cycle.
// - The busy, clear and ZERO_REG rules are unchanged in both builds.
// TESTING (DATA_W=64, ADDR_W=5, ZERO_REG=1)
// - Reset: assert rst and release -> busy=1 for exactly 32 edges, then 0; rdata1/rdata2 read 0 from every address.
// - Write/read: write 0xDEADBEEF_0000_0005 to reg 5 -> raddr1=5 next cycle reads it.
//   Write 0x1234 to reg 0 -> raddr2=0 reads 0.
// - Bypass: write 0xA5 to reg 7 while raddr1=7 in the same cycle (reg 7 holds 0).
//   - REGBANK_BYPASS_EN defined: rdata1=0xA5 that cycle.
//   - Undefined: rdata1=0 that cycle and 0xA5 the next.
// - Busy drop: regwrite reg 3 = 0xFF at edge 2 after reset -> once busy falls, reg 3 reads 0.
// - Clear: fill regs 1..31 with their index, pulse clear -> busy for 32 edges, then all regs read 0.
//   Assert rst when clr_ptr=10 -> sweep restarts and busy lasts 32 more edges.
// - Simultaneous: in IDLE, clear=1 and regwrite reg 9 = 0x77 on one edge -> after the sweep, reg 9 reads 0.

Source files
------------

// File: rtl/register_bank_param.sv
// Parametrised 2R/1W register file with a hardware clear sweep (one entry per cycle).
// Optional write-through forwarding when REGBANK_BYPASS_EN is defined.
module register_bank_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              regwrite,
  input  logic              clear,
  output logic              busy,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              zero_waddr;
  logic [DATA_W-1:0] bank_q [DEPTH];

  assign zero_waddr = (ZERO_REG != 0) && (waddr == '0);
  assign busy       = (state_q == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The sweep borrows the single write port, so user writes are simply lost while busy.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_en     = 1'b0;
    wr_addr   = waddr;
    wr_data   = wdata;
    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = IDLE;
      end
      default: begin
        if (clear) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (regwrite && !zero_waddr) begin
          wr_en = 1'b1;
        end
      end
    endcase
  end

  // Storage has no reset; the sweep makes it deterministic.
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wr_addr] <= wr_data;
  end

`ifdef REGBANK_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = (state_q == IDLE) && regwrite && !clear && !zero_waddr;
`endif

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] r;
    r = bank_q[ra];
`ifdef REGBANK_BYPASS_EN
    if (fwd_ok && (ra == waddr)) r = wdata;
`endif
    if (busy || ((ZERO_REG != 0) && (ra == '0))) r = '0;
    return r;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end
endmodule

// File: tb/tb_register_bank_param.sv
// Randomised self-checking bench for register_bank_param (DATA_W=64, ADDR_W=5, ZERO_REG=1).
module tb_register_bank_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
  logic [63:0] wdata = '0;
  logic        regwrite = 1'b0, clear = 1'b0;
  logic        busy;
  logic [63:0] rdata1, rdata2;

  int checks = 0;
  int failures = 0;

  // Reference: array of values plus count of remaining busy edges.
  logic [63:0] mdl [32];
  int          busy_left = 32;

  register_bank_param #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr),
    .wdata(wdata), .regwrite(regwrite), .clear(clear), .busy(busy),
    .rdata1(rdata1), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (busy_left > 0 || a == 5'd0) return 64'd0;
`ifdef REGBANK_BYPASS_EN
    if (regwrite && !clear && a == waddr && waddr != 5'd0) return wdata;
`endif
    return mdl[a];
  endfunction

  // One rising edge; model applied with the inputs present at that edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) busy_left = 32;
    else if (busy_left > 0) busy_left--;
    else if (clear) begin
      busy_left = 32;
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    end else if (regwrite && waddr != 5'd0) mdl[waddr] = wdata;
    #1;
  endtask

  task automatic idle_inputs();
    regwrite = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    #2 rst = 1'b1;
    busy_left = 32;
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b want=1", busy); end
    checks++;
    if (rdata1 !== 64'd0 || rdata2 !== 64'd0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h want=0", rdata1, rdata2);
    end
    cycle(); cycle();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      raddr1 = 5'($urandom); raddr2 = 5'($urandom); #1;
      checks++;
      if (rdata1 !== 64'd0 || rdata2 !== 64'd0) begin
        failures++; $display("FAIL sweep_rdata n=%0d got=%h/%h want=0", n, rdata1, rdata2);
      end
      cycle(); n++;
    end
    checks++;
    if (n != 32) begin failures++; $display("FAIL reset_busy_len got=%0d want=32", n); end
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
      checks++;
      if (rdata1 !== 64'd0 || rdata2 !== 64'd0) begin
        failures++; $display("FAIL post_reset_zero a=%0d got=%h/%h want=0", a, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_read();
    waddr = 5'd5; wdata = 64'hDEADBEEF_0000_0005; regwrite = 1'b1;
    cycle();
    regwrite = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5; #1;
    checks++;
    if (rdata1 !== 64'hDEADBEEF_0000_0005 || rdata2 !== 64'hDEADBEEF_0000_0005) begin
      failures++; $display("FAIL write_reg5 got=%h/%h want=deadbeef00000005", rdata1, rdata2);
    end
    waddr = 5'd0; wdata = 64'h1234; regwrite = 1'b1;
    cycle();
    regwrite = 1'b0; raddr2 = 5'd0; #1;
    checks++;
    if (rdata2 !== 64'd0) begin failures++; $display("FAIL write_reg0 got=%h want=0", rdata2); end
  endtask

  task automatic test_bypass();
    raddr1 = 5'd7; raddr2 = 5'd5;
    waddr = 5'd7; wdata = 64'hA5; regwrite = 1'b1; #1;
    checks++;
`ifdef REGBANK_BYPASS_EN
    if (rdata1 !== 64'hA5) begin failures++; $display("FAIL bypass_same_cycle got=%h want=a5", rdata1); end
`else
    if (rdata1 !== 64'd0) begin failures++; $display("FAIL bypass_same_cycle got=%h want=0", rdata1); end
`endif
    cycle();
    regwrite = 1'b0; #1;
    checks++;
    if (rdata1 !== 64'hA5) begin failures++; $display("FAIL bypass_next_cycle got=%h want=a5", rdata1); end
  endtask

  task automatic test_busy_drop();
    int n;
    idle_inputs();
    rst = 1'b1; busy_left = 32;
    cycle();
    rst = 1'b0;
    cycle();
    waddr = 5'd3; wdata = 64'hFF; regwrite = 1'b1;
    cycle();
    regwrite = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if (n != 30) begin failures++; $display("FAIL busy_drop_len got=%0d want=30", n); end
    raddr1 = 5'd3; #1;
    checks++;
    if (rdata1 !== 64'd0) begin failures++; $display("FAIL busy_drop_reg3 got=%h want=0", rdata1); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      waddr = 5'(i); wdata = 64'(i); regwrite = 1'b1; cycle();
    end
    regwrite = 1'b0;
    raddr1 = 5'd17; raddr2 = 5'd31; #1;
    checks++;
    if (rdata1 !== 64'd17 || rdata2 !== 64'd31) begin
      failures++; $display("FAIL fill got=%h/%h want=11/1f", rdata1, rdata2);
    end
    clear = 1'b1; cycle(); clear = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if (n != 32) begin failures++; $display("FAIL clear_busy_len got=%0d want=32", n); end
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); #1;
      checks++;
      if (rdata1 !== 64'd0) begin failures++; $display("FAIL clear_zero a=%0d got=%h want=0", a, rdata1); end
    end
    // Reset in the middle of a sweep restarts it from zero.
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1; #1;
    busy_left = 32;
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if (n != 32) begin failures++; $display("FAIL rst_mid_sweep_len got=%0d want=32", n); end
  endtask

  task automatic test_simultaneous();
    int n;
    waddr = 5'd9; wdata = 64'h77; regwrite = 1'b1; clear = 1'b1;
    cycle();
    idle_inputs();
    n = 0;
    while (busy === 1'b1 && n < 100) begin cycle(); n++; end
    checks++;
    if (n != 32) begin failures++; $display("FAIL simul_busy_len got=%0d want=32", n); end
    raddr2 = 5'd9; #1;
    checks++;
    if (rdata2 !== 64'd0) begin failures++; $display("FAIL simul_reg9 got=%h want=0", rdata2); end
  endtask

  task automatic test_random();
    logic [63:0] e1, e2;
    for (int it = 0; it < 600; it++) begin
      raddr1   = 5'($urandom);
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      waddr    = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom);
      wdata    = {$urandom, $urandom};
      regwrite = ($urandom_range(0, 2) != 0);
      clear    = ($urandom_range(0, 49) == 0);
      #1;
      e1 = exp_rd(raddr1);
      e2 = exp_rd(raddr2);
      checks++;
      if (busy !== (busy_left > 0) || rdata1 !== e1 || rdata2 !== e2) begin
        failures++;
        $display("FAIL random it=%0d busy=%0b/%0b r1[%0d]=%h want=%h r2[%0d]=%h want=%h",
                 it, busy, (busy_left > 0), raddr1, rdata1, e1, raddr2, rdata2, e2);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_busy_drop();
    test_clear();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
